// File: rtl/ifmap_feeder.sv
// ifmap_feeder: transmit side of the convolution core's IFMap input buffer.
// On start it clears the core's buffer, reads a row-major feature map from a
// synchronous single-port memory, packs PAR_IN_IF words per beat with
// start/end-of-row tags and pushes each beat over the IF_buff_wen/ready
// handshake, pulsing done after the last accepted beat.
// Optional build macro: IFMAP_FEEDER_PREFETCH_EN adds a second pack register
// so the next beat is fetched while the current one waits for acceptance.
module ifmap_feeder #(
   parameter int IFMap_WIDTH    = 16,
   parameter int PAR_IN_IF      = 2,
   parameter int MEM_ADDR_WIDTH = 12,
   parameter int DIM_WIDTH      = 8
) (
   input  logic                                  clk,
   input  logic                                  rstn,
   input  logic                                  start,
   input  logic [MEM_ADDR_WIDTH-1:0]             base_addr,
   input  logic [DIM_WIDTH-1:0]                  row_len,
   input  logic [DIM_WIDTH-1:0]                  num_rows,
   output logic                                  mem_ren,
   output logic [MEM_ADDR_WIDTH-1:0]             mem_addr,
   input  logic [IFMap_WIDTH-1:0]                mem_rdata,
   output logic                                  IF_buff_clr,
   output logic                                  IF_buff_wen,
   input  logic                                  IF_buff_ready,
   output logic [PAR_IN_IF*(IFMap_WIDTH+2)-1:0]  IFMap,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  err
);

   localparam int LW     = IFMap_WIDTH + 2;
   localparam int BEAT_W = PAR_IN_IF * LW;
   localparam int LANE_W = (PAR_IN_IF > 1) ? $clog2(PAR_IN_IF) : 1;
   localparam int CNT_W  = 2 * DIM_WIDTH;

   localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(PAR_IN_IF - 1);
   localparam logic [CNT_W-1:0]  BEAT_WORDS = CNT_W'(PAR_IN_IF);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_FETCH,
      S_CAPT,
      S_SEND,
      S_DONE
   } state_t;

   state_t                    state_q, state_d;

   // Transfer configuration and progress
   logic [DIM_WIDTH-1:0]      row_len_q, row_len_d;
   logic [DIM_WIDTH-1:0]      col_q, col_d;
   logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LANE_W-1:0]         lane_q, lane_d;
   logic [CNT_W-1:0]          rd_left_q, rd_left_d;   // words still to read
   logic [CNT_W-1:0]          tx_left_q, tx_left_d;   // words still to hand over

   // Read-to-capture pipeline: what the word arriving next cycle belongs to
   logic                      cap_vld_q, cap_vld_d;
   logic [LANE_W-1:0]         cap_lane_q, cap_lane_d;
   logic                      cap_sor_q, cap_sor_d;
   logic                      cap_eor_q, cap_eor_d;

   logic [BEAT_W-1:0]         pack_q, pack_d;
   logic                      err_q, err_d;

`ifdef IFMAP_FEEDER_PREFETCH_EN
   // Output register holds the beat on offer; pack_q becomes the fill buffer
   logic [BEAT_W-1:0]         ob_q, ob_d;
   logic                      ob_full_q, ob_full_d;
   logic                      fb_full_q, fb_full_d;
   logic                      ob_free;
   logic                      cap_last;
`endif

   logic                      legal;
   logic                      start_ok;
   logic                      rd_en;
   logic                      accept;
   logic                      col_last;

   // Handshake and read-enable decisions shared by next-state and datapath
   always_comb begin
      legal    = (row_len != '0) && (num_rows != '0) &&
                 ((32'(row_len) % PAR_IN_IF) == 0);
      start_ok = (state_q == S_IDLE) && start && legal;
      col_last = (col_q == row_len_q - DIM_WIDTH'(1));
`ifdef IFMAP_FEEDER_PREFETCH_EN
      accept   = (state_q == S_FETCH) && ob_full_q && IF_buff_ready;
      ob_free  = !ob_full_q || accept;
      cap_last = cap_vld_q && (cap_lane_q == LAST_LANE);
      // A read lands in the fill buffer next cycle, so it may only issue if
      // the fill buffer will have drained into the output register by then.
      rd_en    = (state_q == S_FETCH) && (rd_left_q != '0) &&
                 (ob_free || !(fb_full_q || cap_last));
`else
      accept   = (state_q == S_SEND) && IF_buff_ready;
      rd_en    = (state_q == S_FETCH);
`endif
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start_ok) state_d = S_CLR;
         S_CLR:   state_d = S_FETCH;
`ifdef IFMAP_FEEDER_PREFETCH_EN
         // Fetch, capture and send overlap; FETCH is the streaming phase
         S_FETCH: if (accept && (tx_left_q == BEAT_WORDS)) state_d = S_DONE;
         S_CAPT:  state_d = S_IDLE;
         S_SEND:  state_d = S_IDLE;
`else
         S_FETCH: if (lane_q == LAST_LANE) state_d = S_CAPT;
         S_CAPT:  state_d = S_SEND;
         S_SEND: begin
            if (accept) begin
               state_d = (tx_left_q == BEAT_WORDS) ? S_DONE : S_FETCH;
            end
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: addressing, column tags, lane capture and beat accounting
   always_comb begin
      row_len_d  = row_len_q;
      col_d      = col_q;
      addr_d     = addr_q;
      lane_d     = lane_q;
      rd_left_d  = rd_left_q;
      tx_left_d  = tx_left_q;
      pack_d     = pack_q;
      cap_vld_d  = rd_en;
      cap_lane_d = lane_q;
      cap_sor_d  = (col_q == '0);
      cap_eor_d  = col_last;
      err_d      = (state_q == S_IDLE) && start && !legal;

      if (start_ok) begin
         row_len_d = row_len;
         addr_d    = base_addr;
         col_d     = '0;
         lane_d    = '0;
         rd_left_d = CNT_W'(row_len) * CNT_W'(num_rows);
         tx_left_d = CNT_W'(row_len) * CNT_W'(num_rows);
      end

      if (rd_en) begin
         addr_d    = addr_q + MEM_ADDR_WIDTH'(1);
         col_d     = col_last ? '0 : col_q + DIM_WIDTH'(1);
         lane_d    = (lane_q == LAST_LANE) ? '0 : lane_q + LANE_W'(1);
         rd_left_d = rd_left_q - CNT_W'(1);
      end

      // Memory data is valid the cycle after its read
      if (cap_vld_q) begin
         pack_d[int'(cap_lane_q)*LW +: LW] = {cap_sor_q, cap_eor_q, mem_rdata};
      end

      if (accept) begin
         tx_left_d = tx_left_q - BEAT_WORDS;
      end
   end

`ifdef IFMAP_FEEDER_PREFETCH_EN
   // Hand completed beats from the fill buffer to the output register
   always_comb begin
      ob_d      = ob_q;
      ob_full_d = ob_full_q;
      fb_full_d = fb_full_q;
      if (cap_last && ob_free) begin
         ob_d      = pack_d;
         ob_full_d = 1'b1;
      end else if (fb_full_q && ob_free) begin
         ob_d      = pack_q;
         ob_full_d = 1'b1;
         fb_full_d = 1'b0;
      end else if (accept) begin
         ob_full_d = 1'b0;
      end
      if (cap_last && !ob_free) begin
         fb_full_d = 1'b1;
      end
   end
`endif

   // State and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         row_len_q  <= '0;
         col_q      <= '0;
         addr_q     <= '0;
         lane_q     <= '0;
         rd_left_q  <= '0;
         tx_left_q  <= '0;
         cap_vld_q  <= 1'b0;
         cap_lane_q <= '0;
         cap_sor_q  <= 1'b0;
         cap_eor_q  <= 1'b0;
         pack_q     <= '0;
         err_q      <= 1'b0;
`ifdef IFMAP_FEEDER_PREFETCH_EN
         ob_q       <= '0;
         ob_full_q  <= 1'b0;
         fb_full_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         row_len_q  <= row_len_d;
         col_q      <= col_d;
         addr_q     <= addr_d;
         lane_q     <= lane_d;
         rd_left_q  <= rd_left_d;
         tx_left_q  <= tx_left_d;
         cap_vld_q  <= cap_vld_d;
         cap_lane_q <= cap_lane_d;
         cap_sor_q  <= cap_sor_d;
         cap_eor_q  <= cap_eor_d;
         pack_q     <= pack_d;
         err_q      <= err_d;
`ifdef IFMAP_FEEDER_PREFETCH_EN
         ob_q       <= ob_d;
         ob_full_q  <= ob_full_d;
         fb_full_q  <= fb_full_d;
`endif
      end
   end

   // Output decode
   always_comb begin
      mem_ren     = rd_en;
      mem_addr    = addr_q;
      IF_buff_clr = (state_q == S_CLR);
      IF_buff_wen = accept;
      busy        = (state_q != S_IDLE);
      done        = (state_q == S_DONE);
      err         = err_q;
`ifdef IFMAP_FEEDER_PREFETCH_EN
      IFMap       = ob_q;
`else
      IFMap       = pack_q;
`endif
   end

endmodule

// File: tb/tb_ifmap_feeder.sv
// Testbench for ifmap_feeder: random memory contents, random legal
// configurations and random ready patterns compared against a word-index
// reference model of the expected beat stream.
module tb_ifmap_feeder;

   localparam int W  = 16;
   localparam int P  = 2;
   localparam int AW = 12;
   localparam int DW = 8;
   localparam int LW = W + 2;
   localparam int BW = P * LW;

   logic          clk = 1'b0;
   logic          rstn, start, IF_buff_ready;
   logic [AW-1:0] base_addr;
   logic [DW-1:0] row_len, num_rows;
   logic          mem_ren, IF_buff_clr, IF_buff_wen, busy, done, err;
   logic [AW-1:0] mem_addr;
   logic [W-1:0]  mem_rdata = '0;
   logic [BW-1:0] IFMap;

   logic [W-1:0]  mem [0:(1<<AW)-1];

   int checks = 0;
   int failures = 0;

   // Monitor bookkeeping (written only by the monitor)
   int            cyc = 0;
   logic [BW-1:0] got_q[$];
   int            wen_cyc[$];
   logic [AW-1:0] rd_q[$];
   int            clr_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0, done_cyc = 0;

   // Snapshots taken by the stimulus
   int g0, r0, c0, d0, e0, b0;
   logic [BW-1:0] exp_q[$];

   ifmap_feeder #(
      .IFMap_WIDTH(W), .PAR_IN_IF(P), .MEM_ADDR_WIDTH(AW), .DIM_WIDTH(DW)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
      .row_len(row_len), .num_rows(num_rows), .mem_ren(mem_ren),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .IF_buff_clr(IF_buff_clr),
      .IF_buff_wen(IF_buff_wen), .IF_buff_ready(IF_buff_ready), .IFMap(IFMap),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

   always @(negedge clk) begin
      if (IF_buff_wen) begin
         got_q.push_back(IFMap);
         wen_cyc.push_back(cyc);
      end
      if (mem_ren) rd_q.push_back(mem_addr);
      if (IF_buff_clr) clr_cnt <= clr_cnt + 1;
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (err) err_cnt <= err_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic snap();
      g0 = got_q.size(); r0 = rd_q.size(); c0 = clr_cnt;
      d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
   endtask

   // Reference: word i of the transfer is memory[(base+i) mod 2^AW], its
   // column is i mod row_len, and beat b carries words b*P .. b*P+P-1.
   task automatic build_exp(input logic [AW-1:0] base, input int rl, input int nr);
      logic [BW-1:0] beat;
      logic [AW-1:0] a;
      int            wi, col;
      exp_q.delete();
      for (int b = 0; b < (rl * nr) / P; b++) begin
         beat = '0;
         for (int k = 0; k < P; k++) begin
            wi  = b * P + k;
            col = wi % rl;
            a   = AW'(int'(base) + wi);
            beat[k*LW +: LW] = {col == 0, col == rl - 1, mem[a]};
         end
         exp_q.push_back(beat);
      end
   endtask

   task automatic start_xfer(input logic [AW-1:0] base, input int rl, input int nr);
      @(posedge clk); #1;
      base_addr = base; row_len = DW'(rl); num_rows = DW'(nr); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input bit rand_ready);
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         if (done_cnt > d0) break;
         #1;
         if (rand_ready) IF_buff_ready = 1'($urandom_range(0, 1));
      end
      #1;
      IF_buff_ready = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic wait_beats(input int n);
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         if (got_q.size() - g0 >= n) break;
      end
   endtask

   task automatic verify(input string tag, input logic [AW-1:0] base, input int rl,
                         input int nr, input bit chk_period);
      int nb, bad, gap;
      build_exp(base, rl, nr);
      nb = got_q.size() - g0;
      check({tag, "_beat_count"}, 64'(nb), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < nb) check($sformatf("%s_beat%0d", tag, i), 64'(got_q[g0+i]), 64'(exp_q[i]));
      check({tag, "_clr_count"}, 64'(clr_cnt - c0), 64'd1);
      check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
      if (nb > 0)
         check({tag, "_done_after_last"}, 64'(done_cyc), 64'(wen_cyc[g0+nb-1] + 1));
      check({tag, "_rd_count"}, 64'(rd_q.size() - r0), 64'(rl * nr));
      bad = 0;
      for (int i = 0; i < rl * nr && r0 + i < rd_q.size(); i++)
         if (rd_q[r0+i] !== AW'(int'(base) + i)) bad++;
      check({tag, "_rd_addrs"}, 64'(bad), 64'd0);
      check({tag, "_busy_after"}, 64'(busy), 64'd0);
      if (chk_period) begin
`ifdef IFMAP_FEEDER_PREFETCH_EN
         gap = P;
`else
         gap = P + 2;
`endif
         bad = 0;
         for (int i = 1; i < nb; i++)
            if (wen_cyc[g0+i] - wen_cyc[g0+i-1] != gap) bad++;
         check({tag, "_beat_period"}, 64'(bad), 64'd0);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_IFMap"}, 64'(IFMap), 64'd0);
      check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
      check({tag, "_mem_ren"}, 64'(mem_ren), 64'd0);
      check({tag, "_clr"}, 64'(IF_buff_clr), 64'd0);
      check({tag, "_wen"}, 64'(IF_buff_wen), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_err"}, 64'(err), 64'd0);
   endtask

   initial begin
      logic [AW-1:0] base;
      int            rl, nr, bad_wen, bad_dat, bad_ren;
      int            ill_rl[3] = '{3, 0, 4};
      int            ill_nr[3] = '{2, 3, 0};

      rstn = 1'b0; start = 1'b0; IF_buff_ready = 1'b1;
      base_addr = '0; row_len = '0; num_rows = '0;
      for (int a = 0; a < (1 << AW); a++) mem[a] = W'(a);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (2) @(posedge clk);

      // Basic transfer, memory[a] = a
      snap();
      start_xfer(12'h010, 4, 2);
      @(negedge clk);
      check("start_clr", 64'(IF_buff_clr), 64'd1);
      check("start_busy", 64'(busy), 64'd1);
      check("start_no_ren", 64'(mem_ren), 64'd0);
      @(negedge clk);
      check("first_ren", 64'(mem_ren), 64'd1);
      check("first_addr", 64'(mem_addr), 64'h010);
      check("first_clr_low", 64'(IF_buff_clr), 64'd0);
      wait_done(1'b0);
      verify("basic", 12'h010, 4, 2, 1'b1);

      for (int a = 0; a < (1 << AW); a++) mem[a] = W'($urandom);

      // Stall on beat 1 with ready low
      base = AW'($urandom);
      build_exp(base, 4, 2);
      snap();
      start_xfer(base, 4, 2);
      wait_beats(1);
      #1;
      IF_buff_ready = 1'b0;
      bad_wen = 0; bad_dat = 0; bad_ren = 0;
      for (int j = 0; j < 9; j++) begin
         @(negedge clk);
         if (IF_buff_wen !== 1'b0) bad_wen++;
         if (j >= 3) begin
            if (IFMap !== exp_q[1]) bad_dat++;
`ifndef IFMAP_FEEDER_PREFETCH_EN
            if (mem_ren !== 1'b0) bad_ren++;
`endif
         end
      end
      check("stall_no_wen", 64'(bad_wen), 64'd0);
      check("stall_data_held", 64'(bad_dat), 64'd0);
      check("stall_no_read", 64'(bad_ren), 64'd0);
      @(posedge clk); #1;
      IF_buff_ready = 1'b1;
      wait_done(1'b0);
      verify("stall", base, 4, 2, 1'b0);

      // Illegal configurations
      for (int t = 0; t < 3; t++) begin
         snap();
         start_xfer(AW'($urandom), ill_rl[t], ill_nr[t]);
         repeat (6) @(posedge clk);
         check($sformatf("illegal%0d_err", t), 64'(err_cnt - e0), 64'd1);
         check($sformatf("illegal%0d_clr", t), 64'(clr_cnt - c0), 64'd0);
         check($sformatf("illegal%0d_reads", t), 64'(rd_q.size() - r0), 64'd0);
         check($sformatf("illegal%0d_beats", t), 64'(got_q.size() - g0), 64'd0);
         check($sformatf("illegal%0d_busy", t), 64'(busy_cnt - b0), 64'd0);
      end

      // Address wrap
      snap();
      start_xfer(12'hFFE, 4, 1);
      wait_done(1'b0);
      verify("wrap", 12'hFFE, 4, 1, 1'b1);
      if (rd_q.size() >= r0 + 4) begin
         check("wrap_addr1", 64'(rd_q[r0+1]), 64'hFFF);
         check("wrap_addr2", 64'(rd_q[r0+2]), 64'h000);
      end

      // Reset in the middle of beat 2
      snap();
      start_xfer(AW'($urandom), 4, 2);
      wait_beats(2);
      #1;
      rstn = 1'b0;
      @(posedge clk);
      snap();
      @(negedge clk);
      check_idle_outputs("midreset");
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (4) @(posedge clk);
      check("midreset_no_reads", 64'(rd_q.size() - r0), 64'd0);
      check("midreset_no_beats", 64'(got_q.size() - g0), 64'd0);
      check("midreset_no_clr", 64'(clr_cnt - c0), 64'd0);
      base = AW'($urandom);
      snap();
      start_xfer(base, 4, 2);
      wait_done(1'b0);
      verify("after_reset", base, 4, 2, 1'b1);

      // Random legal transfers with random back-pressure
      for (int t = 0; t < 4; t++) begin
         base = AW'($urandom);
         rl   = P * int'($urandom_range(1, 5));
         nr   = int'($urandom_range(1, 4));
         snap();
         start_xfer(base, rl, nr);
         wait_done(1'b1);
         verify($sformatf("rand%0d", t), base, rl, nr, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifmap_feeder.md
# ifmap_feeder

Transmit side of the convolution core's IFMap input-buffer interface. On `start` it clears the core's IFMap buffer, streams a row-major feature map out of a synchronous single-port memory, and packs `PAR_IN_IF` words per beat with per-word row tags. It pushes each beat over the `IF_buff_wen`/`IF_buff_ready` handshake and pulses `done` after the last beat is accepted. It sits between the feature-map SRAM and the `IFMap`/`IF_buff_*` ports of the convolution core.

## Interface
Parameters:
- `IFMap_WIDTH`, default 16: data bits per feature word.
- `PAR_IN_IF`, default 2: words per beat; must be ≥1.
- `MEM_ADDR_WIDTH`, default 12: feature-memory address width.
- `DIM_WIDTH`, default 8: width of `row_len` and `num_rows`.

Ports:
- `clk`, in, 1: clock. One clock domain; all state updates on its rising edge.
- `rstn`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: launch a transfer. Sampled only in IDLE.
- `base_addr`, in, `MEM_ADDR_WIDTH`: first word address. Sampled on accepted `start`.
- `row_len`, in, `DIM_WIDTH`: words per row. Sampled on accepted `start`.
- `num_rows`, in, `DIM_WIDTH`: row count. Sampled on accepted `start`.
- `mem_ren`, out, 1: memory read enable.
- `mem_addr`, out, `MEM_ADDR_WIDTH`: memory read address.
- `mem_rdata`, in, `IFMap_WIDTH`: read data, valid the cycle after `mem_ren`.
- `IF_buff_clr`, out, 1: one-cycle clear pulse to the IFMap buffer.
- `IF_buff_wen`, out, 1: beat write strobe.
- `IF_buff_ready`, in, 1: buffer can accept a beat this cycle.
- `IFMap`, out, `PAR_IN_IF*(IFMap_WIDTH+2)`: packed beat.
- `busy`, out, 1: transfer in progress.
- `done`, out, 1: one-cycle completion pulse.
- `err`, out, 1: one-cycle illegal-configuration pulse.

## Operation
- Lane k occupies `IFMap[k*(W+2) +: W+2]` with W = `IFMap_WIDTH`, laid out as {sor, eor, data}.
  - Bit W+1 is start-of-row: set on the row's first word.
  - Bit W is end-of-row: set on the row's last word.
  - Lane 0 holds the lowest address.
- Legal configuration: `row_len` ≠ 0, `num_rows` ≠ 0, and `row_len` a multiple of `PAR_IN_IF`.
  - An illegal `start` pulses `err` for one cycle, returns to IDLE, and issues no clear, read or write.
- Addressing: one incrementing counter from `base_addr`, row-major and contiguous, wrapping modulo 2^`MEM_ADDR_WIDTH`.
- FSM:
  - IDLE: on legal `start`, latch the configuration and go to CLR.
  - CLR: drive `IF_buff_clr`=1 for one cycle, then go to FETCH.
  - FETCH: assert `mem_ren` for `PAR_IN_IF` consecutive cycles with incrementing `mem_addr`, then go to CAPT.
  - CAPT: capture the last lane, then go to SEND.
  - SEND: hold `IFMap` stable. `IF_buff_wen` = `IF_buff_ready` (combinational, SEND only). On acceptance go to FETCH if beats remain, else to DONE.
  - DONE: pulse `done`, then go to IDLE.
- Lane k is captured from `mem_rdata` in the cycle after its read.
- Tags derive from the column counter: sor when column = 0, eor when column = `row_len`−1.
- `busy` is high from the cycle after an accepted `start` through the `done` cycle.
- `start` while busy is ignored.
- `rstn`=0, including mid-transfer, returns to IDLE in one cycle. No further reads or writes are issued. The IFMap buffer is not cleared.

## Timing
- Reset values: every output is 0, including `IFMap`, `mem_addr`, `busy`, `done` and `err`.
- Start sequence: `start` sampled at cycle 0, `IF_buff_clr` at cycle 1, first `mem_ren` at cycle 2.
- Beat period without prefetch: `PAR_IN_IF`+2 cycles minimum, plus one cycle per SEND cycle with ready low.
- `done` is asserted the cycle after the last accepted beat.
- `IF_buff_ready` low during SEND: hold the beat, issue no new reads. There is no timeout.
- `IFMap` is don't-care outside SEND but is held at its last value; no X is allowed after reset.

## Configuration
- `IFMAP_FEEDER_PREFETCH_EN` defined: adds a second pack register.
  - FETCH/CAPT for beat n+1 proceed while beat n waits in SEND.
  - Reads stall only when both registers are full.
  - With `IF_buff_ready` held high, one beat is written every `PAR_IN_IF` cycles after the first beat.
  - Beat order, tags and `done` timing relative to the last acceptance are unchanged.
- `IFMAP_FEEDER_PREFETCH_EN` undefined: single pack register, FSM exactly as above.

## Test plan
- W=16, P=2, base=0x010, row_len=4, num_rows=2, memory[a]=a, ready=1:
  - 1 clear pulse, then 4 beats carrying words 0x10..0x17.
  - Beat 0 has lane0 sor=1. Beat 1 has lane1 eor=1. Beat 2 has lane0 sor=1.
  - `done` asserted 1 cycle after beat 3.
- Same transfer with ready held low for 5 cycles on beat 1: beat 1 data stays stable, `mem_ren` stays 0 while stalled, and all 4 beats arrive in order.
- `row_len`=3 with P=2: `err`=1 for one cycle. `IF_buff_clr`, `mem_ren` and `IF_buff_wen` never assert.
- base=0xFFE, row_len=4, num_rows=1: read addresses are 0xFFE, 0xFFF, 0x000, 0x001.
- `rstn` low during beat 2: all outputs 0 the next cycle. A new `start` afterwards runs a full clean transfer.
- With `IFMAP_FEEDER_PREFETCH_EN` and ready=1: `IF_buff_wen` rises every 2 cycles after the first beat, and the data matches the first scenario.
